// File: rtl/router_ctrl_fsm.sv
// Ingress sequencing controller for the 1x3 router: decodes the header address,
// paces FIFO writes around full conditions and sequences parity load/check.
module router_ctrl_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_reg;
    logic [1:0] sel_idx;
    logic       sel_empty;
    logic       sel_srst;
    logic       hdr_ok;

    assign hdr_ok = pkt_valid && (data_in != 2'd3);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= DECODE_ADDRESS;
            addr_reg <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && hdr_ok)
                addr_reg <= data_in;
        end
    end

    // The header address is not yet latched while decoding, so look at the live bus.
    assign sel_idx = (state == DECODE_ADDRESS) ? data_in : addr_reg;

    always_comb begin
        sel_empty = 1'b0;
        case (sel_idx)
            2'd0:    sel_empty = fifo_empty_0;
            2'd1:    sel_empty = fifo_empty_1;
            2'd2:    sel_empty = fifo_empty_2;
            default: sel_empty = 1'b0;
        endcase
    end

    always_comb begin
        sel_srst = 1'b0;
        case (addr_reg)
            2'd0:    sel_srst = soft_reset_0;
            2'd1:    sel_srst = soft_reset_1;
            2'd2:    sel_srst = soft_reset_2;
            default: sel_srst = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        if (state != DECODE_ADDRESS && sel_srst) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (state)
                DECODE_ADDRESS: begin
                    if (hdr_ok)
                        next_state = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        next_state = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        next_state = LOAD_PARITY;
                    else
                        next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR:
                    next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                WAIT_TILL_EMPTY: begin
                    if (sel_empty)
                        next_state = LOAD_FIRST_DATA;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DECODE_ADDRESS:  detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            default:         detect_add = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: expected Moore output vectors are
// queued as stimulus is applied and compared once the clock edge has landed.
module tb_router_ctrl_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg, busy;

    router_ctrl_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    typedef enum int {S_DEC, S_LFD, S_LD, S_FULL, S_LAF, S_LP, S_CHK, S_WAIT} st_e;
    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  errors = 0;
    int  checks = 0;

    logic [7:0] outs;
    assign outs = {detect_add, lfd_state, ld_state, laf_state,
                   full_state, write_enb_reg, rst_int_reg, busy};

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    function automatic logic [7:0] exp_vec(st_e s);
        case (s)
            S_DEC:   return 8'b1000_0000;
            S_LFD:   return 8'b0100_0001;
            S_LD:    return 8'b0010_0100;
            S_FULL:  return 8'b0000_1001;
            S_LAF:   return 8'b0001_0101;
            S_LP:    return 8'b0000_0101;
            S_CHK:   return 8'b0000_0011;
            S_WAIT:  return 8'b0000_0001;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_state(input string tag, input st_e s);
        sb_t e;
        e.tag = tag;
        e.exp = exp_vec(s);
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        sb_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 8'hff, 8'h00);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, outs, e.exp);
        end
    endtask

    task automatic step(input string tag, input st_e s);
        expect_state(tag, s);
        @(posedge clock);
        #1;
        compare_out();
    endtask

    initial begin
        resetn        = 1'b0;
        pkt_valid     = 1'b0;
        data_in       = 2'd0;
        fifo_full     = 1'b0;
        fifo_empty_0  = 1'b1;
        fifo_empty_1  = 1'b1;
        fifo_empty_2  = 1'b1;
        soft_reset_0  = 1'b0;
        soft_reset_1  = 1'b0;
        soft_reset_2  = 1'b0;
        parity_done   = 1'b0;
        low_pkt_valid = 1'b0;
        #2;
        expect_state("reset", S_DEC);
        compare_out();
        @(negedge clock);
        resetn = 1'b1;

        // Normal packet to port 1: 3 payload cycles then parity.
        pkt_valid = 1'b1; data_in = 2'd1;
        step("t1_hdr", S_LFD);
        data_in = 2'd0;
        step("t1_lfd", S_LD);
        step("t1_ld2", S_LD);
        step("t1_ld3", S_LD);
        pkt_valid = 1'b0;
        step("t1_lp", S_LP);
        step("t1_chk", S_CHK);
        step("t1_dec", S_DEC);

        // Port 2 busy; live bus changes must not matter once address is latched.
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        step("t2_wait", S_WAIT);
        data_in = 2'd0;
        step("t2_wait_hold", S_WAIT);
        fifo_empty_2 = 1'b1;
        step("t2_lfd", S_LFD);
        step("t2_ld", S_LD);
        pkt_valid = 1'b0;
        step("t2_lp", S_LP);
        step("t2_chk", S_CHK);
        step("t2_dec", S_DEC);

        // Invalid address 3 is never accepted.
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 5; i++) step("t3_addr3", S_DEC);
        pkt_valid = 1'b0; data_in = 2'd0;

        // Full handling, full beats !pkt_valid, then LAF exits.
        pkt_valid = 1'b1;
        step("t4_lfd", S_LFD);
        step("t4_ld", S_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        step("t4_full", S_FULL);
        step("t4_full_hold", S_FULL);
        fifo_full = 1'b0;
        step("t4_laf", S_LAF);
        parity_done = 1'b1;
        step("t4_laf_pd", S_DEC);
        parity_done = 1'b0; pkt_valid = 1'b1;
        step("t4b_lfd", S_LFD);
        step("t4b_ld", S_LD);
        fifo_full = 1'b1;
        step("t4b_full", S_FULL);
        fifo_full = 1'b0;
        step("t4b_laf", S_LAF);
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        step("t4b_laf_low", S_LP);
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        step("t4b_chk", S_CHK);
        step("t4b_chk_full", S_FULL);
        fifo_full = 1'b0;
        step("t4c_laf", S_LAF);
        pkt_valid = 1'b1;
        step("t4c_laf_ld", S_LD);
        pkt_valid = 1'b0;
        step("t4c_lp", S_LP);
        step("t4c_chk", S_CHK);
        step("t4c_dec", S_DEC);

        // Soft reset follows the latched port only, and overrides fifo_full.
        fifo_empty_0 = 1'b0; data_in = 2'd0; pkt_valid = 1'b1;
        step("t5_wait", S_WAIT);
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        step("t5_srst_other", S_WAIT);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        step("t5_srst_own", S_DEC);
        soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
        data_in = 2'd1; pkt_valid = 1'b1;
        step("t5b_lfd", S_LFD);
        step("t5b_ld", S_LD);
        fifo_full = 1'b1; soft_reset_1 = 1'b1;
        step("t5b_srst_full", S_DEC);
        fifo_full = 1'b0; soft_reset_1 = 1'b0; pkt_valid = 1'b0;

        // Asynchronous reset mid-payload.
        data_in = 2'd1; pkt_valid = 1'b1;
        step("t6_lfd", S_LFD);
        step("t6_ld", S_LD);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        expect_state("t6_async_rst", S_DEC);
        compare_out();
        @(negedge clock);
        resetn = 1'b1; data_in = 2'd2;
        step("t6_lfd2", S_LFD);
        data_in = 2'd0;
        step("t6_ld2", S_LD);
        pkt_valid = 1'b0;
        step("t6_lp", S_LP);
        step("t6_chk", S_CHK);
        step("t6_dec", S_DEC);

        if (sb_q.size() != 0) check("sb_leftover", 8'(sb_q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
- Ingress sequencing controller for the 1x3 router.
- Watches the incoming packet stream (header, payload, parity) and the state of the three output FIFOs, and drives the control strobes that:
  - latch the destination address;
  - enable FIFO writes;
  - stall the source via busy;
  - sequence parity loading and checking.
- Sits between the input pins and the register/sync/FIFO datapath; its write_enb_reg and detect_add feed the FIFO-select logic.

Parameters:
none (fixed 3 ports, 2-bit address; state encoding is internal)

Ports:
clock  input  1  system clock, all state on posedge
resetn  input  1  asynchronous active-low reset
pkt_valid  input  1  high while header/payload bytes are present on the input bus
data_in  input  2  address field of the input bus (header bits [1:0]); 0,1,2 valid, 3 invalid
fifo_full  input  1  full flag of the currently selected FIFO
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
soft_reset_0  input  1  FIFO 0 timed-out soft reset
soft_reset_1  input  1  FIFO 1 timed-out soft reset
soft_reset_2  input  1  FIFO 2 timed-out soft reset
parity_done  input  1  parity byte already captured by register block
low_pkt_valid  input  1  pkt_valid fell while the datapath was stalled
detect_add  output  1  header decode strobe
lfd_state  output  1  load-first-data (header write) strobe
ld_state  output  1  payload load strobe
laf_state  output  1  load-after-full strobe
full_state  output  1  FIFO-full hold indicator
write_enb_reg  output  1  FIFO write enable request
rst_int_reg  output  1  parity-check / internal reset strobe
busy  output  1  stall request to the source

Behaviour:
- All outputs are Moore: decoded combinationally from the state register only.
- Reset (resetn=0, async):
  - state=DECODE_ADDRESS;
  - addr_reg=0;
  - outputs: detect_add=1, all others 0.
- addr_reg: loads data_in on a clock edge in DECODE_ADDRESS when pkt_valid=1 and data_in!=3; holds otherwise.
- Selected signals:
  - sel_empty = fifo_empty_[data_in] in DECODE_ADDRESS, fifo_empty_[addr_reg] elsewhere.
  - sel_srst = soft_reset_[addr_reg].
- Output decode per state (unlisted outputs 0):
  - DECODE_ADDRESS: detect_add=1, busy=0.
  - LOAD_FIRST_DATA: lfd_state=1, busy=1.
  - LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0.
  - FIFO_FULL_STATE: full_state=1, busy=1.
  - LOAD_AFTER_FULL: laf_state=1, write_enb_reg=1, busy=1.
  - LOAD_PARITY: write_enb_reg=1, busy=1.
  - CHECK_PARITY_ERROR: rst_int_reg=1, busy=1.
  - WAIT_TILL_EMPTY: busy=1.
- Transitions (priority: soft reset first, then listed order):
  - Any state except DECODE_ADDRESS with sel_srst=1 -> DECODE_ADDRESS.
  - DECODE_ADDRESS:
    - pkt_valid & data_in!=3 & sel_empty -> LOAD_FIRST_DATA;
    - pkt_valid & data_in!=3 & !sel_empty -> WAIT_TILL_EMPTY;
    - else stay. data_in==3 is never accepted.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE;
    - else !pkt_valid -> LOAD_PARITY;
    - else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS;
    - else low_pkt_valid -> LOAD_PARITY;
    - else LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else DECODE_ADDRESS.
  - WAIT_TILL_EMPTY: sel_empty -> LOAD_FIRST_DATA; else stay.
- Latency:
  - header accepted to first payload write: 2 cycles (LFD, then LD);
  - pkt_valid fall to parity write: 1 cycle;
  - parity write to DECODE: 2 cycles.
- Simultaneous events:
  - fifo_full and !pkt_valid in LOAD_DATA: full wins.
  - soft reset overrides every other condition, including fifo_full.
- Illegal or unused state encodings recover to DECODE_ADDRESS on the next edge.
- Reset mid-packet: outputs return to reset values immediately (async); packet is abandoned.

Test Plan:
- Header addr 1, FIFO1 empty, 3 payload bytes, then parity. Expected state sequence: DECODE -> LFD -> LD x3 -> LOAD_PARITY -> CHECK -> DECODE. busy=0 only in DECODE/LD; write_enb_reg high 4 cycles; rst_int_reg 1 cycle.
- Header addr 2 with fifo_empty_2=0 -> WAIT_TILL_EMPTY, busy=1, no writes. Drop fifo_empty_2 -> LFD next edge; addr_reg stays 2.
- data_in=3 with pkt_valid=1 for 5 cycles -> remains DECODE, detect_add=1, addr_reg unchanged.
- fifo_full=1 during LD -> FIFO_FULL_STATE, full_state=1, write_enb_reg=0. Release -> LAF. Then:
  - parity_done=1 -> DECODE;
  - low_pkt_valid=1 -> LOAD_PARITY;
  - neither -> LD.
- In WAIT_TILL_EMPTY for addr 0, assert soft_reset_0 -> DECODE next edge; soft_reset_1 has no effect.
- Assert resetn=0 mid-LD -> detect_add=1 and all other outputs 0 without a clock edge; release -> normal header decode.
